// File: rtl/beacon_pkg.sv
// Shared beacon definitions: FSM state encoding and default warm-up/cooldown lengths
// used by both the burst transmitter and the beacon receiver.
package beacon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WARMUP   = 2'd1,
        ST_SYMBOL   = 2'd2,
        ST_COOLDOWN = 2'd3
    } beacon_state_e;

    localparam int BEACON_WARMUP   = 256;
    localparam int BEACON_COOLDOWN = 64;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/beacon_sym_timer.sv
// Symbol-period timer: loadable down-counter (a load value of 0 is treated as 1) whose
// expire flag is high during the last cycle of each symbol.
module beacon_sym_timer #(
    parameter int SYM_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [SYM_W-1:0] len,
    output logic             expire
);

    logic [SYM_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= (len == '0) ? SYM_W'(1) : len;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expire = (cnt == SYM_W'(1));

endmodule

// File: rtl/beacon_burst_tx.sv
// Keyed beacon burst transmitter: warm-up, OOK code word (MSB first), cooldown.
// Define BEACON_BURST_TX_REPEAT_EN to add the rep_cnt port and repeated code-word passes.
module beacon_burst_tx
    import beacon_pkg::*;
#(
    parameter int CODE_LEN  = 16,
    parameter int NUM_CH    = 2,
    parameter int SYM_W     = 8,
    parameter int WARMUP    = BEACON_WARMUP,
    parameter int COOLDOWN  = BEACON_COOLDOWN,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                xtal_in,
    input  logic                rst,
    input  logic                tx_stb,
    input  logic [CODE_LEN-1:0] code,
    input  logic [CH_W-1:0]     ch_sel,
    input  logic [SYM_W-1:0]    sym_len,
`ifdef BEACON_BURST_TX_REPEAT_EN
    input  logic [3:0]          rep_cnt,
`endif
    output logic                pll_en,
    output logic [NUM_CH-1:0]   tx_en,
    output logic                busy,
    output logic                done,
    output logic                drop,
    output logic [1:0]          fsm_state
);

    localparam int CNT_W = $clog2(max_int(WARMUP, COOLDOWN) + 1);
    localparam int IDX_W = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
    localparam logic [CNT_W-1:0] WARM_LOAD = CNT_W'(WARMUP - 1);
    localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'(COOLDOWN - 1);
    localparam logic [IDX_W-1:0] IDX_TOP   = IDX_W'(CODE_LEN - 1);

    beacon_state_e       state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [IDX_W-1:0]    idx, idx_n;
    logic [CODE_LEN-1:0] sh, sh_n;
    logic [CH_W-1:0]     ch_lat, ch_n;
    logic [SYM_W-1:0]    len_lat, len_n;
    logic                fin, fin_n;
    logic                timer_load;
    logic                sym_expire;
    logic [NUM_CH-1:0]   tx_dec;
`ifdef BEACON_BURST_TX_REPEAT_EN
    logic [3:0]          rep, rep_n;
`endif

    beacon_sym_timer #(.SYM_W(SYM_W)) u_sym_timer (
        .clk    (xtal_in),
        .rst    (rst),
        .load   (timer_load),
        .len    (len_lat),
        .expire (sym_expire)
    );

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        idx_n      = idx;
        sh_n       = sh;
        ch_n       = ch_lat;
        len_n      = len_lat;
        fin_n      = 1'b0;
        timer_load = 1'b0;
`ifdef BEACON_BURST_TX_REPEAT_EN
        rep_n      = rep;
`endif
        case (state)
            ST_IDLE: begin
                if (tx_stb) begin
                    state_n = ST_WARMUP;
                    cnt_n   = WARM_LOAD;
                    sh_n    = code;
                    ch_n    = ch_sel;
                    len_n   = sym_len;
`ifdef BEACON_BURST_TX_REPEAT_EN
                    rep_n   = rep_cnt;
`endif
                end
            end
            ST_WARMUP: begin
                if (cnt == '0) begin
                    state_n    = ST_SYMBOL;
                    idx_n      = IDX_TOP;
                    timer_load = 1'b1;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            ST_SYMBOL: begin
                if (sym_expire) begin
                    // Rotate rather than shift so a repeat pass sees the original word again.
                    sh_n = (sh << 1) | (sh >> (CODE_LEN - 1));
                    if (idx == '0) begin
                        state_n = ST_COOLDOWN;
                        cnt_n   = COOL_LOAD;
                    end else begin
                        idx_n      = idx - 1'b1;
                        timer_load = 1'b1;
                    end
                end
            end
            ST_COOLDOWN: begin
                if (cnt == '0) begin
`ifdef BEACON_BURST_TX_REPEAT_EN
                    if (rep != 4'd0) begin
                        rep_n      = rep - 4'd1;
                        state_n    = ST_SYMBOL;
                        idx_n      = IDX_TOP;
                        timer_load = 1'b1;
                    end else begin
                        state_n = ST_IDLE;
                        fin_n   = 1'b1;
                    end
`else
                    state_n = ST_IDLE;
                    fin_n   = 1'b1;
`endif
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_dec = '0;
        if (state == ST_SYMBOL && sh[CODE_LEN-1] && int'(ch_lat) < NUM_CH)
            tx_dec = NUM_CH'(1) << ch_lat;
    end

    // Outputs are registered decodes of the current state, so they trail it by one cycle.
    always_ff @(posedge xtal_in) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            idx     <= '0;
            sh      <= '0;
            ch_lat  <= '0;
            len_lat <= '0;
            fin     <= 1'b0;
`ifdef BEACON_BURST_TX_REPEAT_EN
            rep     <= 4'd0;
`endif
            pll_en  <= 1'b0;
            tx_en   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            drop    <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            idx     <= idx_n;
            sh      <= sh_n;
            ch_lat  <= ch_n;
            len_lat <= len_n;
            fin     <= fin_n;
`ifdef BEACON_BURST_TX_REPEAT_EN
            rep     <= rep_n;
`endif
            pll_en  <= (state == ST_WARMUP) || (state == ST_SYMBOL);
            tx_en   <= tx_dec;
            busy    <= (state != ST_IDLE);
            done    <= fin;
            drop    <= tx_stb && (state != ST_IDLE);
        end
    end

    assign fsm_state = state;

endmodule

// File: tb/tb_beacon_burst_tx.sv
// Self-checking bench for beacon_burst_tx: a cycle model pushes the expected output
// vector for every edge and the sampled DUT outputs are popped and compared against it.
module tb_beacon_burst_tx;

    localparam int CL  = 16;
    localparam int NCH = 3;
    localparam int SW  = 8;
    localparam int WU  = 256;
    localparam int CD  = 64;
    localparam int CHW = 2;
    localparam int OW  = NCH + 4;

    logic            xtal_in = 1'b0;
    logic            rst;
    logic            tx_stb;
    logic [CL-1:0]   code;
    logic [CHW-1:0]  ch_sel;
    logic [SW-1:0]   sym_len;
`ifdef BEACON_BURST_TX_REPEAT_EN
    logic [3:0]      rep_cnt;
`endif
    logic            pll_en;
    logic [NCH-1:0]  tx_en;
    logic            busy;
    logic            done;
    logic            drop;
    logic [1:0]      fsm_state;

    beacon_burst_tx #(
        .CODE_LEN (CL),
        .NUM_CH   (NCH),
        .SYM_W    (SW),
        .WARMUP   (WU),
        .COOLDOWN (CD)
    ) dut (
        .xtal_in   (xtal_in),
        .rst       (rst),
        .tx_stb    (tx_stb),
        .code      (code),
        .ch_sel    (ch_sel),
        .sym_len   (sym_len),
`ifdef BEACON_BURST_TX_REPEAT_EN
        .rep_cnt   (rep_cnt),
`endif
        .pll_en    (pll_en),
        .tx_en     (tx_en),
        .busy      (busy),
        .done      (done),
        .drop      (drop),
        .fsm_state (fsm_state)
    );

    // clock / reset
    always #5 xtal_in = ~xtal_in;

    // scoreboard and model state
    logic [OW-1:0] exp_q[$];
    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;
    bit act = 0;
    int a = 0;
    logic [CL-1:0] m_code;
    int m_len, m_ch, m_rep;

    task automatic check(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            if (err_cnt <= 20)
                $display("FAIL %s cycle %0d: got %b expected %b ({pll,tx_en,busy,done,drop})",
                         tag, cyc, got, exp);
        end
    endtask

    function automatic logic [OW-1:0] model_out(input int t, input logic stb);
        logic pll, bz, dn;
        logic [NCH-1:0] tx;
        int r, le, p, tot, s, q, bitn;
        pll = 1'b0; bz = 1'b0; dn = 1'b0; tx = '0;
        if (act) begin
            r   = t - a;
            le  = (m_len == 0) ? 1 : m_len;
            p   = CL * le + CD;
            tot = WU + (m_rep + 1) * p;
            bz  = (r >= 1 && r <= tot);
            dn  = (r == tot + 1);
            if (r >= 1 && r <= WU) begin
                pll = 1'b1;
            end else if (bz) begin
                s = r - WU - 1;
                q = s % p;
                if (q < CL * le) begin
                    pll  = 1'b1;
                    bitn = CL - 1 - q / le;
                    if (m_code[bitn] && m_ch < NCH) tx[m_ch] = 1'b1;
                end
            end
        end
        return {pll, tx, bz, dn, stb & bz};
    endfunction

    // driver: one clock edge per call, expected vector pushed at drive time
    task automatic tick(input logic r_v, input logic stb, input logic [CL-1:0] c,
                        input logic [CHW-1:0] ch, input logic [SW-1:0] len,
                        input logic [3:0] rep, input string tag);
        logic [OW-1:0] exp;
        @(negedge xtal_in);
        rst = r_v; tx_stb = stb; code = c; ch_sel = ch; sym_len = len;
`ifdef BEACON_BURST_TX_REPEAT_EN
        rep_cnt = rep;
`endif
        if (r_v) begin
            exp = '0;
            act = 0;
        end else begin
            exp = model_out(cyc, stb);
            if (stb && !exp[2]) begin
                act = 1; a = cyc; m_code = c; m_len = int'(len); m_ch = int'(ch);
`ifdef BEACON_BURST_TX_REPEAT_EN
                m_rep = int'(rep);
`else
                m_rep = 0;
`endif
            end
        end
        exp_q.push_back(exp);
        @(posedge xtal_in);
        #1;
        check(tag, {pll_en, tx_en, busy, done, drop}, exp_q.pop_front());
        cyc++;
    endtask

    task automatic idle(input string tag);
        tick(1'b0, 1'b0, CL'($urandom), CHW'($urandom_range(0, 3)), SW'($urandom_range(0, 255)),
             4'($urandom_range(0, 15)), tag);
    endtask

    initial begin
        repeat (3) tick(1'b1, 1'b0, '0, '0, '0, '0, "reset");

        tick(1'b0, 1'b1, 16'hA5F0, 2'd1, 8'd4, 4'd0, "basic");
        repeat (400) idle("basic");

        tick(1'b0, 1'b1, 16'hFFFF, 2'd1, 8'd0, 4'd0, "len0");
        repeat (340) idle("len0");

        repeat (400) tick(1'b0, 1'b1, 16'h1234, 2'd2, 8'd2, 4'd0, "hold");
        repeat (360) idle("hold");

        tick(1'b0, 1'b1, 16'hA5F0, 2'd0, 8'd4, 4'd0, "rst_mid");
        repeat (99) idle("rst_mid");
        tick(1'b1, 1'b0, '0, '0, '0, '0, "rst_mid");
        repeat (9) idle("rst_mid");
        tick(1'b0, 1'b1, 16'h5A0F, 2'd0, 8'd1, 4'd0, "rst_mid");
        repeat (390) idle("rst_mid");

        tick(1'b0, 1'b1, 16'hA5F0, 2'd3, 8'd4, 4'd0, "ch_oob");
        repeat (390) idle("ch_oob");

        for (int i = 0; i < 1500; i++) begin
            tick(1'b0, ($urandom_range(0, 40) == 0), CL'($urandom), CHW'($urandom_range(0, 3)),
                 SW'($urandom_range(0, 3)), 4'($urandom_range(0, 2)), "random");
        end
        repeat (600) idle("random");

`ifdef BEACON_BURST_TX_REPEAT_EN
        tick(1'b0, 1'b1, 16'h8001, 2'd1, 8'd1, 4'd2, "repeat");
        repeat (510) idle("repeat");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
